// File: rtl/tpu_pkg.sv
// Shared TPU types: the byte element carried through the array and the
// drain-state enum used by systolic_data_setup.
package tpu_pkg;

  typedef logic [7:0] byte_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/lane_delay.sv
// DEPTH-stage byte-plus-valid shift register with enable and sync reset;
// one instance per systolic lane provides that lane's skew.
module lane_delay
  import tpu_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enable,
  input  byte_type data_in,
  input  logic     valid_in,
  output byte_type data_out,
  output logic     valid_out
);

  byte_type         data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) data_p[k] <= '0;
      vld_p <= '0;
    end else if (enable) begin
      data_p[0] <= data_in;
      vld_p[0]  <= valid_in;
      for (int k = 1; k < DEPTH; k++) begin
        data_p[k] <= data_p[k-1];
        vld_p[k]  <= vld_p[k-1];
      end
    end
  end

  assign data_out  = data_p[DEPTH-1];
  assign valid_out = vld_p[DEPTH-1];

endmodule

// File: rtl/systolic_data_setup.sv
// Skews unskewed input rows diagonally for the matrix_multiply_unit.
// Optional busy/drain_done status and drain FSM: define SYSTOLIC_SETUP_STATUS_EN.
module systolic_data_setup
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enable,
  input  byte_type data_in [MATRIX_WIDTH],
  input  logic     data_valid,
  input  logic     data_signed,
  output byte_type systolic_data [MATRIX_WIDTH],
  output logic     systolic_signed
`ifdef SYSTOLIC_SETUP_STATUS_EN
  ,
  output logic     busy,
  output logic     drain_done
`endif
);

`ifdef SYSTOLIC_SETUP_STATUS_EN
  logic [MATRIX_WIDTH-1:0] lane_vld;
`endif

  // Lane i is DEPTH=i+1 deep; an idle enabled edge shifts in a zero row.
  for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_lane
    byte_type lane_in;
    assign lane_in = data_valid ? data_in[i] : '0;

    lane_delay #(
      .DEPTH(i + 1)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .data_in  (lane_in),
`ifdef SYSTOLIC_SETUP_STATUS_EN
      .valid_in (data_valid),
      .data_out (systolic_data[i]),
      .valid_out(lane_vld[i])
`else
      .valid_in (1'b0),
      .data_out (systolic_data[i]),
      .valid_out()
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst)         systolic_signed <= 1'b0;
    else if (enable) systolic_signed <= data_valid & data_signed;
  end

`ifdef SYSTOLIC_SETUP_STATUS_EN
  localparam int CNT_W = $clog2(MATRIX_WIDTH + 1);

  drain_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;

  assign busy = |lane_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      drain_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_done <= done_d;
    end
  end

  // The pulse lands on the edge that retires the last row from the deepest lane.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = drain_done;
    if (enable) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (data_valid) state_d = STREAM;
        end
        STREAM: begin
          if (!data_valid) begin
            if (MATRIX_WIDTH == 1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = DRAIN;
              cnt_d   = CNT_W'(MATRIX_WIDTH - 1);
            end
          end
        end
        DRAIN: begin
          if (data_valid) begin
            state_d = STREAM;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_d == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
`endif

endmodule
